// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encodings,
// frame-length constants and serial line levels.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit (11-bit frame).
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam int UART_FRAME_BITS = 11;
`else
    localparam int UART_FRAME_BITS = 10;
`endif

    localparam logic UART_LINE_IDLE  = 1'b1;
    localparam logic UART_LINE_START = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_e;

`ifdef UART_TX_PARITY_EN
    // Even parity: XOR of all data bits, so the total count of ones is even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time generator: counts 0..CLKS_PER_BIT-1 and flags the last count.
// The count is forced back to zero by `restart` so the first bit of a frame
// has an exact width regardless of where the counter was while idle.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart wins, otherwise wrap at the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_byte_tx.sv
// Byte-to-serial transmitter: accepts one byte per tx_data_rdy strobe and
// sends it as an asynchronous frame (start, 8 data LSB first, stop).
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
// All outputs are registered and computed from the next state, so the line
// and busy flag change on the very edge that accepts a byte.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_rdy,
    output logic       tx_busy,
    output logic       tx_overrun,
    output logic       uart_txd
);

    import uart_pkg::*;

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;
    logic       overrun_q, overrun_d;
    logic       restart;
    logic       bit_tick;
`ifdef UART_TX_PARITY_EN
    logic       parity_q, parity_d;
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .bit_tick (bit_tick)
    );

    // Next-state, datapath and output decode for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;
        restart   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        // Any strobe that arrives while a frame is in flight is lost.
        if (tx_data_rdy && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                txd_d  = UART_LINE_IDLE;
                busy_d = 1'b0;
                if (tx_data_rdy) begin
                    shift_d   = tx_data;
                    bit_cnt_d = '0;
                    restart   = 1'b1;
                    state_d   = ST_START;
                    txd_d     = UART_LINE_START;
                    busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d  = even_parity(tx_data);
`endif
                end
            end

            ST_START: begin
                if (bit_tick) begin
                    state_d = ST_DATA;
                    txd_d   = shift_q[0];
                end
            end

            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = ST_STOP;
                        txd_d   = UART_LINE_IDLE;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d = ST_STOP;
                    txd_d   = UART_LINE_IDLE;
                end
            end
`endif

            ST_STOP: begin
                if (bit_tick) begin
                    state_d = ST_IDLE;
                    txd_d   = UART_LINE_IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                txd_d   = UART_LINE_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset truncates any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            txd_q     <= UART_LINE_IDLE;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign uart_txd   = txd_q;
    assign tx_busy    = busy_q;
    assign tx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx with CLKS_PER_BIT=4. Stimulus pushes the expected
// byte (and parity) into a queue; a line monitor decodes every frame seen
// on uart_txd and compares it against the head of the queue.
module tb_uart_byte_tx;

    import uart_pkg::*;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = UART_FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_rdy = 1'b0;
    logic       tx_busy;
    logic       tx_overrun;
    logic       uart_txd;

    uart_byte_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_data_rdy (tx_data_rdy),
        .tx_busy     (tx_busy),
        .tx_overrun  (tx_overrun),
        .uart_txd    (uart_txd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle strobe; optionally record the frame the line must carry.
    task automatic send(input logic [7:0] b, input logic par, input bit expect_it);
        exp_t e;
        e.data = b;
        e.par  = par;
        if (expect_it) sb_q.push_back(e);
        tx_data     = b;
        tx_data_rdy = 1'b1;
        step();
        tx_data_rdy = 1'b0;
        $display("send 0x%02h expected=%0d", b, expect_it);
    endtask

    // Expected line level during bit slot k of a frame carrying b.
    function automatic logic frame_level(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (tx_busy && cyc < 500) begin
            step();
            cyc++;
        end
        check(name, tx_busy, 1'b0);
    endtask

    // Line monitor: detects the start edge, samples each bit mid-slot.
    logic       prev_txd = 1'b1;
    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    int         mon_k = 0;
    int         frames_seen = 0;
    logic [7:0] mon_byte = 8'h00;
`ifdef UART_TX_PARITY_EN
    logic       mon_par = 1'b0;
`endif
    exp_t       mon_e;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (prev_txd === 1'b1 && uart_txd === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % CPB == CPB / 2) begin
                mon_k = mon_cnt / CPB;
                if (mon_k == 0) begin
                    check("start_bit", uart_txd, 1'b0);
                end else if (mon_k <= 8) begin
                    mon_byte[mon_k-1] = uart_txd;
`ifdef UART_TX_PARITY_EN
                end else if (mon_k == 9) begin
                    mon_par = uart_txd;
`endif
                end else begin
                    check("stop_bit", uart_txd, 1'b1);
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %02h expected none", mon_byte);
                    end else begin
                        mon_e = sb_q.pop_front();
                        $display("rx frame 0x%02h expected 0x%02h", mon_byte, mon_e.data);
                        check("rx_byte", mon_byte, mon_e.data);
`ifdef UART_TX_PARITY_EN
                        check("rx_parity", mon_par, mon_e.par);
`endif
                    end
                    frames_seen++;
                    mon_active = 1'b0;
                end
            end
        end
        prev_txd = uart_txd;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int bad;
        int exp_frames;

        exp_frames = 0;

        // Reset state
        repeat (3) step();
        check("rst_txd", uart_txd, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_overrun", tx_overrun, 1'b0);
        rst = 1'b0;
        step();

        // 0x41: exact waveform and busy length
        send(8'h41, 1'b0, 1);
        exp_frames++;
        cyc = 0;
        bad = 0;
        while (tx_busy && cyc < 500) begin
            if (uart_txd !== frame_level(8'h41, cyc / CPB)) bad++;
            step();
            cyc++;
        end
        check("busy_len_41", cyc, FRAME_CYC);
        check("wave_41", bad, 0);
        check("txd_after_41", uart_txd, 1'b1);
        repeat (5) step();
        check("overrun_after_41", tx_overrun, 1'b0);

`ifdef UART_TX_PARITY_EN
        // 0x07 carries an odd number of ones: parity bit 1
        send(8'h07, 1'b1, 1);
        exp_frames++;
        wait_idle("idle_07");
        repeat (4) step();
`endif

        // Back-to-back: second strobe on the first not-busy cycle
        send(8'h0D, 1'b1, 1);
        exp_frames++;
        wait_idle("idle_0d");
        send(8'h0A, 1'b0, 1);
        exp_frames++;
        check("b2b_busy", tx_busy, 1'b1);
        check("b2b_txd_start", uart_txd, 1'b0);
        wait_idle("idle_0a");
        repeat (4) step();
        check("b2b_overrun", tx_overrun, 1'b0);
        check("b2b_sb_empty", sb_q.size(), 0);

        // Overrun: 0x34 strobed at cycle 10 of the 0x33 frame
        send(8'h33, 1'b0, 1);
        exp_frames++;
        repeat (10) step();
        check("ovr_before", tx_overrun, 1'b0);
        send(8'h34, 1'b1, 0);
        check("ovr_set", tx_overrun, 1'b1);
        check("ovr_busy_kept", tx_busy, 1'b1);
        wait_idle("idle_33");
        repeat (20) step();
        check("ovr_sticky", tx_overrun, 1'b1);
        check("ovr_sb_empty", sb_q.size(), 0);

        // Reset in the middle of a 0x55 frame
        send(8'h55, 1'b0, 0);
        repeat (17) step();
        check("mid_txd_low", uart_txd, 1'b0);
        rst = 1'b1;
        step();
        check("midrst_txd", uart_txd, 1'b1);
        check("midrst_busy", tx_busy, 1'b0);
        check("midrst_overrun", tx_overrun, 1'b0);
        rst = 1'b0;
        step();
        send(8'h55, 1'b0, 1);
        exp_frames++;
        wait_idle("idle_55");
        repeat (4) step();

        // Long idle with no strobes
        rst = 1'b1;
        step();
        rst = 1'b0;
        bad = 0;
        repeat (1000) begin
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
            step();
        end
        check("idle_1000", bad, 0);

        check("sb_empty", sb_q.size(), 0);
        check("frames_seen", frames_seen, exp_frames);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
